// File: rtl/fb_ram_rop_if.sv
`default_nettype none
// ============================================================================
//  Module      : fb_ram_rop_if
//  Description : Access-port bundle for the fb_ram_rop framebuffer.
//                The draw engine (master) drives a pixel coordinate, the
//                request strobes and the raster-op operands. The framebuffer
//                (slave) returns rdy, read data with its valid pulse, and the
//                out-of-bounds pulse.
//  Ports       : x, y          pixel coordinate (master -> slave)
//                read, write   request strobes, read has priority
//                fill          span fill strobe (used only with FB_FILL_EN)
//                rop           0 COPY, 1 AND, 2 OR, 3 XOR
//                wdata         write operand
//                fill_len      span length in pixels
//                rdy           slave idle, requests accepted while high
//                rd_data       read result
//                rd_valid      one-cycle pulse when rd_data is valid
//                oob           one-cycle pulse for an out-of-range request
//  Revision    : 1.0  initial release
// ============================================================================
interface fb_ram_rop_if #(
   parameter int XW         = 9,
   parameter int YW         = 8,
   parameter int PIX_BITS   = 1,
   parameter int FILL_LEN_W = 9
);
   logic [XW-1:0]         x;
   logic [YW-1:0]         y;
   logic                  read;
   logic                  write;
   logic                  fill;
   logic [1:0]            rop;
   logic [PIX_BITS-1:0]   wdata;
   logic [FILL_LEN_W-1:0] fill_len;
   logic                  rdy;
   logic [PIX_BITS-1:0]   rd_data;
   logic                  rd_valid;
   logic                  oob;

   modport master (
      output x, y, read, write, fill, rop, wdata, fill_len,
      input  rdy, rd_data, rd_valid, oob
   );

   modport slave (
      input  x, y, read, write, fill, rop, wdata, fill_len,
      output rdy, rd_data, rd_valid, oob
   );
endinterface
`default_nettype wire

// File: rtl/fb_ram_rop.sv
`default_nettype none
// ============================================================================
//  Module      : fb_ram_rop
//  Description : Parametrised single-clock WIDTH x HEIGHT x PIX_BITS
//                framebuffer. A fully pipelined read-only scan port feeds the
//                display timing generator; a handshaked access port serves
//                the draw engine with read, write and read-modify-write
//                raster ops (COPY/AND/OR/XOR), clipping and an oob flag.
//  Ports       : clk         sole clock
//                rst         synchronous active-high reset (memory kept)
//                scan_x/y    scan coordinate, registered every cycle
//                scan_data   scan pixel, valid after the second edge
//                            following the address edge; 0 when out of range
//                acc         access port (fb_ram_rop_if.slave)
//  Options     : FB_FILL_EN  enables horizontal span fill (state FILL)
//  Revision    : 1.0  initial release
// ============================================================================
module fb_ram_rop #(
   parameter int  WIDTH      = 320,
   parameter int  HEIGHT     = 240,
   parameter int  PIX_BITS   = 1,
   parameter int  FILL_LEN_W = 9,
   localparam int XW         = $clog2(WIDTH),
   localparam int YW         = $clog2(HEIGHT),
   localparam int AW         = $clog2(WIDTH * HEIGHT)
) (
   input  wire logic                clk,
   input  wire logic                rst,
   input  wire logic [XW-1:0]       scan_x,
   input  wire logic [YW-1:0]       scan_y,
   output      logic [PIX_BITS-1:0] scan_data,
   fb_ram_rop_if.slave              acc
);
   localparam int         DEPTH      = WIDTH * HEIGHT;
   // One extra bit so a power-of-two WIDTH/HEIGHT still fits the compare.
   localparam logic [XW:0] c_width   = (XW + 1)'(WIDTH);
   localparam logic [YW:0] c_height  = (YW + 1)'(HEIGHT);
   localparam logic [1:0] c_rop_copy = 2'd0;
   localparam logic [1:0] c_rop_and  = 2'd1;
   localparam logic [1:0] c_rop_or   = 2'd2;
   localparam logic [1:0] c_rop_xor  = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_WAIT = 3'd1,
      ST_RD_OUT  = 3'd2,
      ST_RMW_RD  = 3'd3,
      ST_RMW_WR  = 3'd4,
      ST_WR      = 3'd5
`ifdef FB_FILL_EN
      ,ST_FILL   = 3'd6
`endif
   } state_t;

   logic [PIX_BITS-1:0] r_mem [DEPTH];

   // ------------------------------------------------------------------------
   // Scan port: address stage, memory stage, output stage.
   // ------------------------------------------------------------------------
   logic                w_scan_inb;
   logic [AW-1:0]       w_scan_addr;
   logic                r_scan_inb;
   logic [AW-1:0]       r_scan_addr;
   logic [PIX_BITS-1:0] r_scan_q;

   assign w_scan_inb  = ({1'b0, scan_x} < c_width) && ({1'b0, scan_y} < c_height);
   assign w_scan_addr = AW'(scan_x) + AW'(scan_y) * AW'(WIDTH);

   // The memory stage reads with non-blocking semantics, so a same-edge
   // access write is seen only on the next scan of that pixel (read-first).
   always_ff @(posedge clk) begin
      if (rst) begin
         r_scan_inb  <= 1'b0;
         r_scan_addr <= '0;
         r_scan_q    <= '0;
         scan_data   <= '0;
      end else begin
         r_scan_inb  <= w_scan_inb;
         r_scan_addr <= w_scan_addr;
         r_scan_q    <= r_scan_inb ? r_mem[r_scan_addr] : '0;
         scan_data   <= r_scan_q;
      end
   end

   // ------------------------------------------------------------------------
   // Access port
   // ------------------------------------------------------------------------
   state_t              r_state;
   logic [AW-1:0]       r_addr;
   logic                r_inb;
   logic [1:0]          r_rop;
   logic [PIX_BITS-1:0] r_wdata;
   logic [PIX_BITS-1:0] r_rd_q;
   logic                w_acc_inb;
   logic [AW-1:0]       w_acc_addr;
   logic                w_req;
   logic [PIX_BITS-1:0] w_rop_res;
   logic                w_mem_we;
   logic [PIX_BITS-1:0] w_mem_wdata;

   assign w_acc_inb  = ({1'b0, acc.x} < c_width) && ({1'b0, acc.y} < c_height);
   assign w_acc_addr = AW'(acc.x) + AW'(acc.y) * AW'(WIDTH);

`ifdef FB_FILL_EN
   localparam int CNTW = (FILL_LEN_W > XW + 1) ? FILL_LEN_W : XW + 1;

   logic [CNTW-1:0] r_fill_cnt;
   logic [CNTW-1:0] w_fill_span;
   logic [CNTW-1:0] w_fill_cnt;

   assign w_req       = acc.read | acc.write | acc.fill;
   // Pixels left on the row from the start column; clips the span.
   assign w_fill_span = CNTW'(WIDTH) - CNTW'(acc.x);
   assign w_fill_cnt  = !w_acc_inb ? '0 :
                        (CNTW'(acc.fill_len) < w_fill_span) ? CNTW'(acc.fill_len) :
                        w_fill_span;
`else
   logic                  w_unused_fill;
   logic [FILL_LEN_W-1:0] w_unused_fill_len;

   assign w_req             = acc.read | acc.write;
   assign w_unused_fill     = acc.fill;
   assign w_unused_fill_len = acc.fill_len;
`endif

   always_comb begin
      case (r_rop)
         c_rop_and: w_rop_res = r_rd_q & r_wdata;
         c_rop_or:  w_rop_res = r_rd_q | r_wdata;
         c_rop_xor: w_rop_res = r_rd_q ^ r_wdata;
         default:   w_rop_res = r_wdata;
      endcase
   end

   // Store strobe; suppressed while rst is high so a store edge that
   // coincides with reset never commits.
   always_comb begin
      w_mem_we    = 1'b0;
      w_mem_wdata = r_wdata;
      case (r_state)
         ST_WR:     w_mem_we = r_inb;
         ST_RMW_WR: begin
            w_mem_we    = r_inb;
            w_mem_wdata = w_rop_res;
         end
`ifdef FB_FILL_EN
         // Count is forced to zero at acceptance for an oob start.
         ST_FILL:   w_mem_we = (r_fill_cnt != '0);
`endif
         default:   w_mem_we = 1'b0;
      endcase
      if (rst) begin
         w_mem_we = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[r_addr] <= w_mem_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_addr       <= '0;
         r_inb        <= 1'b0;
         r_rop        <= c_rop_copy;
         r_wdata      <= '0;
         r_rd_q       <= '0;
         acc.rdy      <= 1'b1;
         acc.rd_data  <= '0;
         acc.rd_valid <= 1'b0;
         acc.oob      <= 1'b0;
`ifdef FB_FILL_EN
         r_fill_cnt   <= '0;
`endif
      end else begin
         acc.rd_valid <= 1'b0;
         acc.oob      <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_req) begin
                  r_addr  <= w_acc_addr;
                  r_inb   <= w_acc_inb;
                  r_rop   <= acc.rop;
                  r_wdata <= acc.wdata;
                  acc.oob <= !w_acc_inb;
                  acc.rdy <= 1'b0;
                  if (acc.read) begin
                     r_state <= ST_RD_WAIT;
                  end else if (acc.write) begin
                     r_state <= (acc.rop == c_rop_copy) ? ST_WR : ST_RMW_RD;
                  end
`ifdef FB_FILL_EN
                  else begin
                     r_fill_cnt <= w_fill_cnt;
                     r_state    <= ST_FILL;
                  end
`endif
               end
            end
            ST_RD_WAIT: begin
               r_rd_q  <= r_inb ? r_mem[r_addr] : '0;
               r_state <= ST_RD_OUT;
            end
            ST_RD_OUT: begin
               acc.rd_data  <= r_rd_q;
               acc.rd_valid <= 1'b1;
               acc.rdy      <= 1'b1;
               r_state      <= ST_IDLE;
            end
            ST_RMW_RD: begin
               r_rd_q  <= r_inb ? r_mem[r_addr] : '0;
               r_state <= ST_RMW_WR;
            end
            ST_RMW_WR: begin
               acc.rdy <= 1'b1;
               r_state <= ST_IDLE;
            end
            ST_WR: begin
               acc.rdy <= 1'b1;
               r_state <= ST_IDLE;
            end
`ifdef FB_FILL_EN
            ST_FILL: begin
               r_addr <= r_addr + 1'b1;
               if (r_fill_cnt != '0) begin
                  r_fill_cnt <= r_fill_cnt - 1'b1;
               end
               if (r_fill_cnt <= CNTW'(1)) begin
                  acc.rdy <= 1'b1;
                  r_state <= ST_IDLE;
               end
            end
`endif
            default: begin
               acc.rdy <= 1'b1;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end
endmodule
`default_nettype wire

// File: doc/fb_ram_rop.md
Name: fb_ram_rop

Overview:
- Parametrised single-clock framebuffer memory; next generation of the 1-bit 320x240 two-port pixel RAM.
- Generalised to arbitrary WIDTH x HEIGHT x PIX_BITS, with inferred storage instead of fixed block primitives.
- Two ports:
  - Scan port: fully pipelined, read-only, feeds the display timing generator.
  - Access port: handshaked, serves the GPU draw engine. Supports read, write, and read-modify-write raster ops (COPY/AND/OR/XOR), with clipping and an out-of-bounds flag.

Parameters:
- WIDTH, 320: pixels per row.
- HEIGHT, 240: rows.
- PIX_BITS, 1: bits per pixel.
- FILL_LEN_W, 9: width of the fill length field (used only with FB_FILL_EN).
- Derived:
  - XW = clog2(WIDTH), YW = clog2(HEIGHT).
  - AW = clog2(WIDTH*HEIGHT); linear address = x + y*WIDTH, computed at AW bits.

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- scan_x  in  XW  scan pixel column.
- scan_y  in  YW  scan pixel row.
- scan_data  out  PIX_BITS  scan pixel, 2-cycle latency.
- x  in  XW  access column.
- y  in  YW  access row.
- read  in  1  read request.
- write  in  1  write request.
- fill  in  1  span fill request (FB_FILL_EN only).
- rop  in  2  raster op: 0 COPY, 1 AND, 2 OR, 3 XOR.
- wdata  in  PIX_BITS  write operand.
- fill_len  in  FILL_LEN_W  span length in pixels.
- rdy  out  1  access port idle; requests are accepted only while high.
- rd_data  out  PIX_BITS  read result.
- rd_valid  out  1  one-cycle pulse when rd_data is valid.
- oob  out  1  one-cycle pulse: accepted request had x>=WIDTH or y>=HEIGHT.

Behaviour:
- Reset values: scan_data=0, rd_data=0, rd_valid=0, oob=0, rdy=1, state=IDLE.
- Memory contents are not cleared by rst.
- Scan port:
  - Address registered at edge N; memory read at N+1; scan_data valid after edge N+2.
  - Accepts a new address every cycle; unaffected by access-port activity.
  - Out-of-range scan coordinates return 0.
- Access-port acceptance:
  - A request is accepted at an edge where rdy=1 and one of read/write/fill is high.
  - Priority: read > write > fill.
  - x, y, rop, wdata and fill_len are captured at acceptance and may change afterwards.
- States: IDLE, RD_WAIT, RD_OUT, RMW_RD, RMW_WR, WR, FILL.
- Read:
  - IDLE -> RD_WAIT (memory read) -> RD_OUT (rd_data registered, rd_valid=1, rdy=1) -> IDLE.
  - rdy is low for 2 cycles; rd_valid pulses in the cycle after edge T+2.
- Write, rop=COPY:
  - IDLE -> WR; wdata is stored at edge T+1; rdy is low for 1 cycle.
- Write, rop=AND/OR/XOR:
  - IDLE -> RMW_RD (old pixel read) -> RMW_WR (stores old op wdata) -> IDLE.
  - rdy is low for 2 cycles.
- Out-of-bounds request:
  - Accepted; no memory access; oob pulses the cycle after acceptance; normal state sequence and latency preserved.
  - A read returns rd_data=0 with rd_valid.
- Same-address collision: scan read and access write to one address on the same edge -> scan returns old data (read-first).
- Back-to-back requests: read/write held high continuously are accepted every time rdy returns high; no request is lost or duplicated.
- Reset mid-operation: any in-flight request is dropped. A write whose store edge coincides with rst is not committed; rd_valid does not fire.

Optional Feature:
- Macro: FB_FILL_EN.
- With FB_FILL_EN, fill writes wdata (COPY only; rop ignored) to pixels x .. x+fill_len-1 on row y, one pixel per cycle in state FILL.
  - The span is clipped at column WIDTH-1.
  - fill_len=0, or an out-of-bounds start: no writes; rdy low 1 cycle; oob pulses only for out-of-bounds.
  - rdy returns high the cycle after the last write.
- Without FB_FILL_EN: the fill and fill_len inputs are ignored, FILL state is absent, and fill never clears rdy.

Test Plan:
- Reset, then write (x=5, y=2, wdata=1, rop=COPY), then read (5,2) -> rdy low 1 cycle for the write; rd_data=1 with rd_valid exactly 2 edges after the read is accepted; scan (5,2) gives scan_data=1 two cycles later.
- Pixel (10,10)=1, then write rop=XOR wdata=1 -> rdy low 2 cycles; a subsequent read returns 0. Repeat with OR wdata=1 -> reads 1; AND wdata=0 -> reads 0.
- Write (x=320, y=0) with WIDTH=320 -> oob pulses once; pixel (0,1) unchanged. Read (0,240) -> rd_data=0, rd_valid=1, oob=1.
- read and write both high at the same rdy edge -> read executes first; write is accepted on the next rdy edge; final memory holds wdata.
- Scan (7,7) while access writes 1 to (7,7) on the same edge (old value 0) -> scan_data=0, then 1 on the following scan of (7,7).
- FB_FILL_EN, x=315, y=3, fill_len=10, wdata=1 -> pixels 315..319 on row 3 set; rdy low 5 cycles; (0,4) untouched. Assert rst during a fill -> fill stops, rdy=1 the next cycle.
